// File: rtl/wallace_pkg.sv
// Shared definitions for the pipelined Wallace-tree multiplier.
//   PIPE_LAT         : cycles from accept to out_valid
//   MIN/MAX_WIDTH    : legal operand width range
//   stage_t          : payload of the final carry-save stage (sized for MAX_WIDTH)
//   csa_* functions  : row bookkeeping for the 3:2 reduction tree
package wallace_pkg;
    localparam int PIPE_LAT  = 4;
    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 32;
    localparam int MAX_PROD  = 2 * MAX_WIDTH;

    typedef struct packed {
        logic                valid;
        logic                is_signed;
        logic [MAX_PROD-1:0] sum;
        logic [MAX_PROD-1:0] carry;
        logic                acc_en;
    } stage_t;

    // Rows left after one level of 3:2 compression.
    function automatic int csa_next_rows(input int n);
        return (n / 3) * 2 + (n % 3);
    endfunction

    function automatic int csa_rows_at(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) r = csa_next_rows(r);
        return r;
    endfunction

    // Levels needed to bring n rows down to a sum/carry pair.
    function automatic int csa_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = csa_next_rows(r);
            l++;
        end
        return l;
    endfunction
endpackage

// File: rtl/wallace_csa_row.sv
// One row of N full-adder 3:2 compressors.
//   x_i, y_i, z_i : three addend rows
//   sum_o         : bitwise sum
//   carry_o       : carries already weighted (shifted left by one); the carry
//                   out of the top bit is dropped since the product is mod 2^N
module wallace_csa_row
    import wallace_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic [N-1:0] z_i,
    output logic [N-1:0] sum_o,
    output logic [N-1:0] carry_o
);
    assign sum_o        = x_i ^ y_i ^ z_i;
    assign carry_o[0]   = 1'b0;
    assign carry_o[N-1:1] = (x_i[N-2:0] & y_i[N-2:0]) |
                            (x_i[N-2:0] & z_i[N-2:0]) |
                            (y_i[N-2:0] & z_i[N-2:0]);
endmodule

// File: rtl/wallace_mult_pipe.sv
// Four-stage pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH,
// with valid/ready flow control and per-operation signed/unsigned mode.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready = global advance)
//   in_signed           : 1 = two's-complement operands
//   a, b                : operands
//   out_valid/out_ready : result handshake
//   out_product         : result register, holds its value while not valid
//   acc_en              : only with WALLACE_MAC_EN defined; adds the running
//                         accumulator to this product, 0 restarts accumulation
// Stages: S1 partial products (Baugh-Wooley when signed), S2/S3 carry-save
// reduction split roughly in half, S4 Brent-Kung final add.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef WALLACE_MAC_EN
    input  logic               acc_en,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product
);
    localparam int P    = 2 * WIDTH;
    localparam int NLEV = csa_levels(WIDTH);
    localparam int NL2  = (NLEV + 1) / 2;

    logic             adv;
    logic             acc_en_in;
    logic [P-1:0]     pp_d [WIDTH];
    logic             s1_valid_q, s1_signed_q, s1_acc_q;
    logic [P-1:0]     s1_pp_q [WIDTH];
    logic             s2_valid_q, s2_signed_q, s2_acc_q;
    logic [P-1:0]     s2_rows_q [WIDTH];
    stage_t           s3_d, s3_q;
    logic [P-1:0]     lv_in  [NLEV][WIDTH];
    logic [P-1:0]     lv_out [NLEV][WIDTH];
    logic [P-1:0]     prod;
    logic [P-1:0]     out_product_d;
    logic             out_valid_q;
    logic [P-1:0]     out_product_q;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_product = out_product_q;

`ifdef WALLACE_MAC_EN
    assign acc_en_in = acc_en;
`else
    assign acc_en_in = 1'b0;
`endif

    // Baugh-Wooley: in signed mode the cross terms involving exactly one sign
    // bit are inverted, and the correction constants 2^W and 2^(2W-1) ride in
    // the unused upper bits of row 0 so no extra row is needed.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp_d[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                pp_d[i][i+j] = (a[j] & b[i]) ^
                               (in_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
            end
        end
        pp_d[0][WIDTH] = in_signed;
        pp_d[0][P-1]   = in_signed;
    end

    // Reduction tree: levels 0..NL2-1 run between S1 and S2, the rest between
    // S2 and S3. Rows beyond the live count at each level are tied to zero.
    for (genvar l = 0; l < NLEV; l++) begin : g_lvl
        localparam int NIN  = csa_rows_at(WIDTH, l);
        localparam int NGRP = NIN / 3;
        localparam int NOUT = csa_rows_at(WIDTH, l + 1);

        for (genvar k = 0; k < WIDTH; k++) begin : g_src
            if (l == 0) begin : g_from_s1
                assign lv_in[l][k] = s1_pp_q[k];
            end else if (l == NL2) begin : g_from_s2
                assign lv_in[l][k] = s2_rows_q[k];
            end else begin : g_chain
                assign lv_in[l][k] = lv_out[l-1][k];
            end
        end

        for (genvar g = 0; g < NGRP; g++) begin : g_csa
            wallace_csa_row #(.N(P)) u_row (
                .x_i     (lv_in[l][3*g]),
                .y_i     (lv_in[l][3*g+1]),
                .z_i     (lv_in[l][3*g+2]),
                .sum_o   (lv_out[l][2*g]),
                .carry_o (lv_out[l][2*g+1])
            );
        end

        for (genvar k = 3*NGRP; k < NIN; k++) begin : g_pass
            assign lv_out[l][k-NGRP] = lv_in[l][k];
        end

        for (genvar k = NOUT; k < WIDTH; k++) begin : g_zero
            assign lv_out[l][k] = '0;
        end
    end

    always_comb begin
        s3_d              = '0;
        s3_d.valid        = s2_valid_q;
        s3_d.is_signed    = s2_signed_q;
        s3_d.acc_en       = s2_acc_q;
        s3_d.sum[P-1:0]   = lv_out[NLEV-1][0];
        s3_d.carry[P-1:0] = lv_out[NLEV-1][1];
    end

    function automatic logic [P-1:0] bk_add(input logic [P-1:0] x, input logic [P-1:0] y);
        logic [P-1:0] g, p, h;
        g = x & y;
        p = x ^ y;
        h = p;
        // up-sweep: nodes at 2d-1, 4d-1, ... absorb the block d below
        for (int d = 1; d < P; d = d * 2) begin
            for (int i = 2*d - 1; i < P; i = i + 2*d) begin
                g[i] = g[i] | (h[i] & g[i-d]);
                h[i] = h[i] & h[i-d];
            end
        end
        // down-sweep: fill in the odd multiples from the completed prefixes
        for (int d = P; d >= 1; d = d / 2) begin
            for (int i = 3*d - 1; i < P; i = i + 2*d) begin
                g[i] = g[i] | (h[i] & g[i-d]);
                h[i] = h[i] & h[i-d];
            end
        end
        return p ^ (g << 1);
    endfunction

    assign prod = bk_add(s3_q.sum[P-1:0], s3_q.carry[P-1:0]);

`ifdef WALLACE_MAC_EN
    logic [P-1:0] acc_q;
    assign out_product_d = prod + (s3_q.acc_en ? acc_q : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (adv && s3_q.valid) begin
            acc_q <= out_product_d;
        end
    end
`else
    assign out_product_d = prod;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_signed_q   <= 1'b0;
            s1_acc_q      <= 1'b0;
            s1_pp_q       <= '{default: '0};
            s2_valid_q    <= 1'b0;
            s2_signed_q   <= 1'b0;
            s2_acc_q      <= 1'b0;
            s2_rows_q     <= '{default: '0};
            s3_q          <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
        end else if (adv) begin
            s1_valid_q  <= in_valid;
            s1_signed_q <= in_signed;
            s1_acc_q    <= acc_en_in;
            s1_pp_q     <= pp_d;
            s2_valid_q  <= s1_valid_q;
            s2_signed_q <= s1_signed_q;
            s2_acc_q    <= s1_acc_q;
            for (int k = 0; k < WIDTH; k++) s2_rows_q[k] <= lv_out[NL2-1][k];
            s3_q        <= s3_d;
            out_valid_q <= s3_q.valid;
            if (s3_q.valid) out_product_q <= out_product_d;
        end
    end

    // Mode travels with the data for traceability only; the arithmetic is
    // already fixed by S1. Padding above 2*WIDTH is always zero.
    logic unused_stage_flags;
    assign unused_stage_flags = s3_q.is_signed ^ s3_q.acc_en;

    if (P < MAX_PROD) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^{s3_q.sum[MAX_PROD-1:P], s3_q.carry[MAX_PROD-1:P]};
    end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
module tb_wallace_mult_pipe;
    import wallace_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic [W-1:0]  a, b;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_product;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_out = 0;
    int first_out = 0;
    int last_out  = 0;
    logic [31:0] cur_exp;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wallace_mult_pipe #(.WIDTH(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .a           (a),
        .b           (b),
`ifdef WALLACE_MAC_EN
        .acc_en      (1'b0),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product)
    );

`ifdef WALLACE_MAC_EN
    logic        m_in_valid, m_in_ready, m_acc_en, m_out_valid;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_out_product;

    wallace_mult_pipe #(.WIDTH(8)) u_mac (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (m_in_valid),
        .in_ready    (m_in_ready),
        .in_signed   (1'b0),
        .a           (m_a),
        .b           (m_b),
        .acc_en      (m_acc_en),
        .out_valid   (m_out_valid),
        .out_ready   (1'b1),
        .out_product (m_out_product)
    );
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input logic sg);
        longint px, py;
        px = sg ? longint'($signed(x)) : longint'({48'd0, x});
        py = sg ? longint'($signed(y)) : longint'({48'd0, y});
        return 32'(px * py);
    endfunction

    // One clock: score the output the consumer takes, log the input the DUT
    // takes, then advance to 1 time unit after the next rising edge.
    task automatic cycle(output bit accepted);
        logic [31:0] want;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_out", 64'(out_valid), 64'd0);
            end else begin
                want = exp_q.pop_front();
                check("result", 64'(out_product), 64'(want));
            end
            if (n_out == 0) first_out = cyc;
            last_out = cyc;
            n_out++;
        end
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic sg, input logic [31:0] e);
        bit acc;
        a = x; b = y; in_signed = sg; cur_exp = e; in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 16 && !acc; t++) cycle(acc);
        if (!acc) check("accept_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic drain(input string tag);
        bit acc;
        in_valid = 1'b0;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) cycle(acc);
        cycle(acc);
        cycle(acc);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    logic [15:0] dir_a [12];
    logic [15:0] dir_b [12];
    logic        dir_s [12];
    logic [31:0] dir_e [12];

    initial begin
        bit acc;
        int sent;
        int leak;
        logic [31:0] snap;
        logic [15:0] ra, rb;
        logic        rs;

        dir_a = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                  16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234, 16'h1234};
        dir_b = '{16'hFFFF, 16'h8000, 16'h0002, 16'h0002, 16'h8000, 16'hFFFF,
                  16'h8000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h0010};
        dir_s = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        dir_e = '{32'hFFFE0001, 32'h40000000, 32'hFFFFFFFE, 32'h0001FFFE,
                  32'h00000000, 32'h00000000, 32'hC0008000, 32'h00000001,
                  32'h40000000, 32'h3FFF0001, 32'hFFFFDB98, 32'h00012340};

        rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; a = '0; b = '0;
        out_ready = 1'b1; cur_exp = '0; snap = '0;
`ifdef WALLACE_MAC_EN
        m_in_valid = 1'b0; m_acc_en = 1'b0; m_a = '0; m_b = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_product", 64'(out_product), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Exact latency on the unsigned corner
        a = 16'hFFFF; b = 16'hFFFF; in_signed = 1'b0; in_valid = 1'b1;
        #1;
        check("t1_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i < PIPE_LAT; i++) begin
            check("t1_not_yet_valid", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        check("t1_valid_at_lat", 64'(out_valid), 64'd1);
        check("t1_product", 64'(out_product), 64'h0000_0000_FFFE_0001);
        @(posedge clk);
        #1;
        check("t1_bubble_valid", 64'(out_valid), 64'd0);
        check("t1_product_retained", 64'(out_product), 64'h0000_0000_FFFE_0001);

        // Directed corners, signed and unsigned mixed back to back
        n_out = 0;
        for (int i = 0; i < 12; i++) send(dir_a[i], dir_b[i], dir_s[i], dir_e[i]);
        drain("directed_drain");
        check("directed_count", 64'(n_out), 64'd12);

        // 20 back-to-back random pairs
        n_out = 0;
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            send(ra, rb, rs, model(ra, rb, rs));
        end
        drain("stream_drain");
        check("stream_count", 64'(n_out), 64'd20);
        check("stream_consecutive", 64'(last_out - first_out), 64'd19);

        // Backpressure for 5 cycles mid-stream
        n_out = 0;
        sent = 0;
        ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
        a = ra; b = rb; in_signed = rs; cur_exp = model(ra, rb, rs); in_valid = 1'b1;
        for (int c = 0; c < 60 && sent < 12; c++) begin
            out_ready = !(c >= 6 && c < 11);
            #1;
            if (!out_ready) begin
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_valid_hold", 64'(out_valid), 64'd1);
                if (c == 6) snap = out_product;
                else check("bp_product_hold", 64'(out_product), 64'(snap));
            end
            cycle(acc);
            if (acc) begin
                sent++;
                ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
                a = ra; b = rb; in_signed = rs; cur_exp = model(ra, rb, rs);
            end
        end
        out_ready = 1'b1;
        drain("bp_drain");
        check("bp_count", 64'(n_out), 64'd12);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) send(16'h0101 + 16'(i), 16'h0203, 1'b0, 32'h0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_out_product", 64'(out_product), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        leak = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) leak++;
        end
        check("rst_no_leak", 64'(leak), 64'd0);
        n_out = 0;
        send(16'h8000, 16'h8000, 1'b1, 32'h40000000);
        drain("post_rst_drain");
        check("post_rst_count", 64'(n_out), 64'd1);

`ifdef WALLACE_MAC_EN
        begin
            logic [7:0]  mac_a [4];
            logic [7:0]  mac_b [4];
            logic        mac_e [4];
            logic [15:0] mac_x [4];
            logic [15:0] m_res [4];
            int          m_got;
            mac_a = '{8'd3, 8'd5, 8'd2, 8'd1};
            mac_b = '{8'd4, 8'd6, 8'd2, 8'd1};
            mac_e = '{1'b0, 1'b1, 1'b1, 1'b0};
            mac_x = '{16'd12, 16'd42, 16'd46, 16'd1};
            m_res = '{default: '0};
            m_got = 0;
            for (int i = 0; i < 4; i++) begin
                m_a = mac_a[i]; m_b = mac_b[i]; m_acc_en = mac_e[i]; m_in_valid = 1'b1;
                @(posedge clk);
                #1;
                if (m_out_valid && m_got < 4) begin m_res[m_got] = m_out_product; m_got++; end
            end
            m_in_valid = 1'b0;
            for (int t = 0; t < 12 && m_got < 4; t++) begin
                @(posedge clk);
                #1;
                if (m_out_valid) begin m_res[m_got] = m_out_product; m_got++; end
            end
            check("mac_count", 64'(m_got), 64'd4);
            for (int i = 0; i < 4; i++) check("mac_result", 64'(m_res[i]), 64'(mac_x[i]));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
